// File: rtl/midi_rx.sv
// ---------------------------------------------------------------------------
// midi_rx : MIDI (31250 baud, 8N1) serial receiver with a one-byte holding
//           register, framing-error and overrun reporting.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per MIDI bit (even, >= 8)
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous, active-high reset
//   rx        : asynchronous serial line, idles high
//   rd_ack    : consumer takes the held byte this cycle
//   data      : last received byte
//   valid     : data holds an unread byte
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overrun   : one-cycle pulse when an unread byte is overwritten
// ---------------------------------------------------------------------------
module midi_rx #(
   parameter int unsigned CLKS_PER_BIT = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_ack,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             cnt_zero;

   assign cnt_zero  = (cnt_q == '0);

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; every sample point is a counter expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!rx_s_q) state_d = ST_START;
         ST_START: if (cnt_zero) state_d = rx_s_q ? ST_IDLE : ST_DATA;
         ST_DATA:  if (cnt_zero && (idx_q == 3'd7)) state_d = ST_STOP;
         ST_STOP:  if (cnt_zero) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rx_s_q) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      // Consumer handshake; a byte completing this cycle overrides it below
      if (valid_q && rd_ack) valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) cnt_d = HALF_LOAD;
         end
         ST_START: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!rx_s_q) begin
               idx_d = 3'd0;
               cnt_d = FULL_LOAD;
            end
         end
         ST_DATA: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shift_d = {rx_s_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               cnt_d   = FULL_LOAD;
            end
         end
         ST_STOP: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rx_s_q) begin
               data_d    = shift_q;
               valid_d   = 1'b1;
               // An acknowledge in the completion cycle frees the slot
               overrun_d = valid_q && !rd_ack;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule

// File: tb/tb_midi_rx.sv
// ---------------------------------------------------------------------------
// tb_midi_rx : self-checking bench for midi_rx (CLKS_PER_BIT = 32).
//   A table of single frames is sent and checked, followed by hand-written
//   sequences for glitch rejection, break, overrun, same-cycle acknowledge,
//   back-to-back frames and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_midi_rx;

   localparam int CPB = 32;
   localparam int LAT = CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rd_ack;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   midi_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rd_ack    (rd_ack),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled on the falling edge
   int   fe_cnt = 0;
   int   ov_cnt = 0;
   int   vr_cnt = 0;
   int   rise_cyc = 0;
   logic valid_prev = 1'b0;
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (valid === 1'b1 && valid_prev !== 1'b1) begin
         vr_cnt++;
         rise_cyc = cyc;
      end
      valid_prev = valid;
   end

   int checks = 0;
   int errors = 0;
   int t_fall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one frame. stop_len shortens/lengthens the stop bit, ack_done
   // raises rd_ack in the cycle the stop bit is sampled, rst_bit >= 0 pulses
   // reset halfway through that frame bit and abandons the frame.
   task automatic send(input logic [7:0] b, input logic stop_bit, input int stop_len,
                       input bit ack_done, input int rst_bit);
      logic [9:0] frame;
      int         len;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         len = (i == 9) ? stop_len : CPB;
         for (int k = 0; k < len; k++) begin
            if (i == 0 && k == 0) t_fall = cyc + 2;
            rx     = frame[i];
            rd_ack = ack_done && (i == 9) && (k == 18);
            reset  = (i == rst_bit) && (k == CPB / 2);
            @(posedge clk);
            #1;
            if (reset) begin
               reset  = 1'b0;
               rd_ack = 1'b0;
               rx     = 1'b1;
               return;
            end
         end
      end
      rd_ack = 1'b0;
      rx     = 1'b1;
   endtask

   task automatic ack_byte(input string name);
      rd_ack = 1'b1;
      idle(1);
      rd_ack = 1'b0;
      check({name, " valid cleared by rd_ack"}, 32'(valid), 32'd0);
   endtask

   typedef struct {
      logic [7:0] tx;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_valid;
      int         exp_fe;
   } vec_t;

   vec_t vecs[6];
   int   fe0, ov0, vr0;

   initial begin
      vecs[0] = '{tx: 8'h90, stop: 1'b1, exp_data: 8'h90, exp_valid: 1'b1, exp_fe: 0};
      vecs[1] = '{tx: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_valid: 1'b1, exp_fe: 0};
      vecs[2] = '{tx: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_valid: 1'b1, exp_fe: 0};
      vecs[3] = '{tx: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_valid: 1'b1, exp_fe: 0};
      vecs[4] = '{tx: 8'h3C, stop: 1'b0, exp_data: 8'hA5, exp_valid: 1'b0, exp_fe: 1};
      vecs[5] = '{tx: 8'h45, stop: 1'b1, exp_data: 8'h45, exp_valid: 1'b1, exp_fe: 0};

      rx     = 1'b1;
      rd_ack = 1'b0;
      reset  = 1'b1;
      idle(3);
      reset  = 1'b0;
      idle(1);

      check("reset data", 32'(data), 32'h00);
      check("reset valid", 32'(valid), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);

      // rd_ack with nothing held does nothing
      rd_ack = 1'b1;
      idle(3);
      rd_ack = 1'b0;
      check("idle ack valid", 32'(valid), 32'd0);
      check("idle ack data", 32'(data), 32'h00);

      // Table of single frames
      for (int n = 0; n < 6; n++) begin
         fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vr_cnt;
         send(vecs[n].tx, vecs[n].stop, CPB, 1'b0, -1);
         idle(4);
         check($sformatf("vec%0d data", n), 32'(data), 32'(vecs[n].exp_data));
         check($sformatf("vec%0d valid", n), 32'(valid), 32'(vecs[n].exp_valid));
         check($sformatf("vec%0d valid rises", n), 32'(vr_cnt - vr0), 32'(vecs[n].exp_valid));
         check($sformatf("vec%0d frame_err cycles", n), 32'(fe_cnt - fe0), 32'(vecs[n].exp_fe));
         check($sformatf("vec%0d overrun cycles", n), 32'(ov_cnt - ov0), 32'd0);
         if (vecs[n].exp_valid)
            check($sformatf("vec%0d latency", n), 32'(rise_cyc - t_fall), 32'(LAT));
         ack_byte($sformatf("vec%0d", n));
      end

      // Start-bit glitch of 8 cycles is rejected
      fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vr_cnt;
      rx = 1'b0;
      idle(8);
      rx = 1'b1;
      idle(40);
      check("glitch valid rises", 32'(vr_cnt - vr0), 32'd0);
      check("glitch frame_err", 32'(fe_cnt - fe0), 32'd0);
      check("glitch overrun", 32'(ov_cnt - ov0), 32'd0);
      send(8'h5A, 1'b1, CPB, 1'b0, -1);
      idle(2);
      check("post-glitch data", 32'(data), 32'h5A);
      check("post-glitch latency", 32'(rise_cyc - t_fall), 32'(LAT));
      ack_byte("post-glitch");

      // Bad stop bit followed by a long break
      fe0 = fe_cnt; vr0 = vr_cnt;
      send(8'h3C, 1'b0, CPB + 100, 1'b0, -1);
      idle(4);
      check("break frame_err cycles", 32'(fe_cnt - fe0), 32'd1);
      check("break valid", 32'(valid), 32'd0);
      check("break valid rises", 32'(vr_cnt - vr0), 32'd0);
      check("break data kept", 32'(data), 32'h5A);
      send(8'h45, 1'b1, CPB, 1'b0, -1);
      idle(2);
      check("after break data", 32'(data), 32'h45);
      check("after break valid", 32'(valid), 32'd1);
      ack_byte("after break");

      // Back-to-back frames without acknowledge: overrun
      fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vr_cnt;
      send(8'h11, 1'b1, 17, 1'b0, -1);
      send(8'h22, 1'b1, CPB, 1'b0, -1);
      idle(4);
      check("overrun cycles", 32'(ov_cnt - ov0), 32'd1);
      check("overrun data", 32'(data), 32'h22);
      check("overrun valid", 32'(valid), 32'd1);
      check("overrun valid rises", 32'(vr_cnt - vr0), 32'd1);
      check("overrun frame_err", 32'(fe_cnt - fe0), 32'd0);
      ack_byte("overrun");

      // Acknowledge in the exact completion cycle: no overrun
      ov0 = ov_cnt;
      send(8'h11, 1'b1, CPB, 1'b0, -1);
      idle(2);
      check("ack-same first data", 32'(data), 32'h11);
      send(8'h22, 1'b1, CPB, 1'b1, -1);
      idle(4);
      check("ack-same overrun", 32'(ov_cnt - ov0), 32'd0);
      check("ack-same data", 32'(data), 32'h22);
      check("ack-same valid", 32'(valid), 32'd1);
      ack_byte("ack-same");

      // Reset in the middle of data bit 4 of 0x7F
      fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vr_cnt;
      send(8'h7F, 1'b1, CPB, 1'b0, 5);
      check("mid reset data", 32'(data), 32'h00);
      check("mid reset valid", 32'(valid), 32'd0);
      idle(12 * CPB);
      check("mid reset valid rises", 32'(vr_cnt - vr0), 32'd0);
      check("mid reset frame_err", 32'(fe_cnt - fe0), 32'd0);
      check("mid reset overrun", 32'(ov_cnt - ov0), 32'd0);
      send(8'hF8, 1'b1, CPB, 1'b0, -1);
      idle(2);
      check("after reset data", 32'(data), 32'hF8);
      check("after reset valid", 32'(valid), 32'd1);
      check("after reset latency", 32'(rise_cyc - t_fall), 32'(LAT));
      ack_byte("after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
